// File: rtl/ace_snoop_ctrl.sv
// ace_snoop_ctrl: ACE snoop-port controller arbitrating into the D-cache tag/data SRAM.
// Define SNOOP_CTRL_CLEAN_SHARED_EN to serve CleanShared; otherwise it is answered with Error.
module ace_snoop_ctrl #(
  parameter int NumWays     = 8,
  parameter int AddrWidth   = 64,
  parameter int IndexWidth  = 12,
  parameter int TagWidth    = 44,
  parameter int LineWidth   = 128,
  parameter int CdDataWidth = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         bypass_i,
  input  logic                         flushing_i,
  input  logic                         amo_valid_i,
  input  logic [AddrWidth-1:0]         amo_addr_i,
  input  logic                         updating_cache_i,
  output logic                         busy_o,
  input  logic                         ac_valid_i,
  output logic                         ac_ready_o,
  input  logic [AddrWidth-1:0]         ac_addr_i,
  input  logic [3:0]                   ac_snoop_i,
  output logic                         cr_valid_o,
  input  logic                         cr_ready_i,
  output logic [4:0]                   cr_resp_o,
  output logic                         cd_valid_o,
  input  logic                         cd_ready_i,
  output logic [CdDataWidth-1:0]       cd_data_o,
  output logic                         cd_last_o,
  output logic [NumWays-1:0]           req_o,
  output logic [IndexWidth-1:0]        addr_o,
  output logic [TagWidth-1:0]          tag_o,
  input  logic                         gnt_i,
  output logic                         we_o,
  output logic [NumWays-1:0]           be_vldrty_o,
  output logic                         wr_valid_o,
  output logic                         wr_dirty_o,
  output logic                         wr_shared_o,
  input  logic [NumWays*LineWidth-1:0] rdata_i,
  input  logic [NumWays-1:0]           hit_way_i,
  input  logic [NumWays-1:0]           dirty_way_i,
  input  logic [NumWays-1:0]           shared_way_i,
  input  logic [NumWays-1:0]           miss_inval_req_i,
  input  logic [IndexWidth-1:0]        miss_inval_addr_i,
  output logic                         invalidate_o,
  output logic [AddrWidth-1:0]         invalidate_addr_o,
  output logic                         rs_done_valid_o,
  output logic [AddrWidth-1:0]         rs_done_addr_o
);
  localparam int Beats = LineWidth / CdDataWidth;
  localparam int BeatW = Beats > 1 ? $clog2(Beats) : 1;
  localparam int OffW  = $clog2(LineWidth / 8);
  localparam logic [3:0] ReadOnce     = 4'b0000;
  localparam logic [3:0] ReadShared   = 4'b0001;
  localparam logic [3:0] ReadUnique   = 4'b0111;
  localparam logic [3:0] CleanShared  = 4'b1000;
  localparam logic [3:0] CleanInvalid = 4'b1001;
  localparam logic [3:0] MakeInvalid  = 4'b1101;
`ifdef SNOOP_CTRL_CLEAN_SHARED_EN
  localparam bit CsEn = 1'b1;
`else
  localparam bit CsEn = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WAIT_GNT, EVAL_FLAGS, WRITE_STATE, SEND_CR, SEND_CD} state_e;

  state_e                              state_q;
  logic [AddrWidth-1:0]                addr_q;
  logic [3:0]                          snoop_q;
  logic [4:0]                          resp_q;
  logic [NumWays-1:0]                  hit_q, coll_q;
  logic                                dirty_q;
  logic [Beats-1:0][CdDataWidth-1:0]   line_q;
  logic [BeatW-1:0]                    beat_q;
  logic [NumWays-1:0][LineWidth-1:0]   ways;
  logic [LineWidth-1:0]                hit_line;
  logic [4:0]                          eval_resp;
  logic                                eval_write, supported, same_line, hit, dirty, shared, inval, coll, last;

  assign ways      = rdata_i;
  assign supported = ac_snoop_i inside {ReadOnce, ReadShared, ReadUnique, CleanInvalid, MakeInvalid} ||
                     (CsEn && ac_snoop_i == CleanShared);
  assign same_line = ((amo_addr_i ^ ac_addr_i) >> OffW) == '0;
  assign hit       = |hit_way_i;
  assign dirty     = |(hit_way_i & dirty_way_i);
  assign shared    = |(hit_way_i & shared_way_i);
  assign inval     = snoop_q inside {ReadUnique, CleanInvalid, MakeInvalid};
  assign coll      = |(coll_q & hit_q);
  assign last      = beat_q == BeatW'(Beats - 1);

  always_comb begin
    hit_line = '0;
    for (int w = 0; w < NumWays; w++) hit_line |= hit_way_i[w] ? ways[w] : '0;
  end

  // Only supported snoops reach EVAL_FLAGS, so everything but ReadOnce updates state on a hit.
  always_comb begin
    eval_resp  = '0;
    eval_write = 1'b0;
    if (hit) begin
      eval_resp[4] = !shared;
      eval_write   = snoop_q != ReadOnce;
      case (snoop_q)
        ReadOnce:     eval_resp[3:0] = {shared, 2'b00, 1'b1};
        ReadShared:   eval_resp[3:0] = 4'b1001;
        ReadUnique:   eval_resp[3:0] = {1'b0, dirty, 2'b01};
        CleanInvalid: eval_resp[3:0] = {1'b0, dirty, 1'b0, dirty};
        CleanShared:  eval_resp[3:0] = {1'b1, dirty, 1'b0, dirty};
        default:      eval_resp[3:0] = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      snoop_q <= '0;
      resp_q  <= '0;
      hit_q   <= '0;
      coll_q  <= '0;
      dirty_q <= 1'b0;
      line_q  <= '0;
      beat_q  <= '0;
    end else begin
      if (state_q != IDLE && miss_inval_addr_i == addr_q[IndexWidth-1:0]) coll_q <= coll_q | miss_inval_req_i;
      case (state_q)
        IDLE: if (ac_ready_o) begin
          addr_q  <= ac_addr_i;
          snoop_q <= ac_snoop_i;
          coll_q  <= '0;
          hit_q   <= '0;
          dirty_q <= 1'b0;
          resp_q  <= (bypass_i || supported) ? 5'b00000 : 5'b00010;
          state_q <= (bypass_i || !supported) ? SEND_CR : WAIT_GNT;
        end
        WAIT_GNT: if (gnt_i) state_q <= EVAL_FLAGS;
        EVAL_FLAGS: begin
          hit_q   <= hit_way_i;
          dirty_q <= dirty;
          line_q  <= hit_line;
          resp_q  <= eval_resp;
          state_q <= eval_write ? WRITE_STATE : SEND_CR;
        end
        WRITE_STATE: if (gnt_i) state_q <= SEND_CR;
        SEND_CR: if (cr_ready_i) state_q <= resp_q[0] ? SEND_CD : IDLE;
        SEND_CD: if (cd_ready_i) begin
          beat_q <= last ? '0 : beat_q + 1'b1;
          if (last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ac_ready_o is gated by rst_ni so nothing is offered while reset is held.
  assign busy_o            = state_q != IDLE;
  assign ac_ready_o        = rst_ni && state_q == IDLE && ac_valid_i && !flushing_i && !(amo_valid_i && same_line);
  assign cr_valid_o        = state_q == SEND_CR;
  assign cr_resp_o         = resp_q;
  assign cd_valid_o        = state_q == SEND_CD;
  assign cd_data_o         = cd_valid_o ? line_q[beat_q] : '0;
  assign cd_last_o         = cd_valid_o && last;
  assign req_o             = updating_cache_i ? '0 :
                             state_q inside {WAIT_GNT, EVAL_FLAGS} ? '1 :
                             state_q == WRITE_STATE ? hit_q : '0;
  assign addr_o            = addr_q[IndexWidth-1:0];
  assign tag_o             = addr_q[IndexWidth +: TagWidth];
  assign we_o              = state_q == WRITE_STATE;
  assign be_vldrty_o       = we_o ? hit_q : '0;
  assign wr_valid_o        = we_o && !inval && !coll;
  assign wr_dirty_o        = we_o && snoop_q == ReadShared && dirty_q;
  assign wr_shared_o       = we_o && !inval;
  assign invalidate_o      = we_o && inval;
  assign invalidate_addr_o = addr_q;
  assign rs_done_valid_o   = we_o && snoop_q == ReadShared && gnt_i;
  assign rs_done_addr_o    = addr_q;
endmodule
